// File: rtl/s9234_bist_pkg.sv
// Shared constants for the s9234 scan/BIST wrapper: chain geometry,
// TPG seed and the x^7+x+1 feedback tap masks used by the TPG and the MISR.
package s9234_bist_pkg;

    localparam int unsigned N_CHAINS  = 7;
    localparam int unsigned NUM_FLOPS = 228;
    localparam int unsigned NUM_PI    = 36;
    localparam int unsigned NUM_PO    = 39;

    localparam int unsigned CHAIN_LEN [N_CHAINS] = '{33, 33, 33, 33, 32, 32, 32};

    localparam logic [N_CHAINS-1:0] TPG_SEED  = 7'b0000001;
    localparam logic [N_CHAINS-1:0] MISR_SEED = '0;

    // Feedback bit = q[6] ^ q[5]
    localparam logic [N_CHAINS-1:0] TPG_TAPS  = 7'b1100000;
    localparam logic [N_CHAINS-1:0] MISR_TAPS = 7'b1100000;

    typedef enum logic {
        LFSR_TPG  = 1'b0,
        LFSR_MISR = 1'b1
    } lfsr_mode_e;

    // Index of the first flop of chain c in the flat core state vector.
    function automatic int unsigned chain_base(input int unsigned c);
        int unsigned base;
        base = 0;
        for (int unsigned i = 0; i < c; i++) begin
            base += CHAIN_LEN[i];
        end
        return base;
    endfunction

endpackage

// File: rtl/s9234_scan_bist_core.sv
// Scan-stitched s9234 core: 228 flops in seven chains (33,33,33,33,32,32,32),
// compact behavioural model of the generated netlist's capture and output logic.
module s9234_core_scan
    import s9234_bist_pkg::*;
(
    input  logic                CK,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [N_CHAINS-1:0] scan_in,
    output logic [N_CHAINS-1:0] scan_out,
    input  logic [NUM_PI-1:0]   pi,
    output logic [NUM_PO-1:0]   po
);

    logic [NUM_FLOPS-1:0] state;
    logic [NUM_FLOPS-1:0] shift_d;
    logic [NUM_FLOPS-1:0] func_d;

    // Flat vector shifts up by one; each chain head is then overridden by its scan-in,
    // which also cuts the link from the previous chain's tail.
    always_comb begin
        shift_d  = {state[NUM_FLOPS-2:0], 1'b0};
        scan_out = '0;
        for (int unsigned c = 0; c < N_CHAINS; c++) begin
            shift_d[chain_base(c)] = scan_in[c];
            scan_out[c]            = state[chain_base(c) + CHAIN_LEN[c] - 1];
        end
    end

    always_comb begin
        func_d = '0;
        for (int unsigned i = 0; i < NUM_FLOPS; i++) begin
            func_d[i] = state[(i * 37 + 11) % NUM_FLOPS]
                      ^ (state[(i * 53 + 5) % NUM_FLOPS] & ~state[(i * 101 + 3) % NUM_FLOPS])
                      ^ pi[i % NUM_PI];
        end
    end

    always_comb begin
        po = '0;
        for (int unsigned j = 0; j < NUM_PO; j++) begin
            po[j] = state[(j * 5 + 2) % NUM_FLOPS]
                  ^ (state[(j * 13 + 7) % NUM_FLOPS] | pi[(j * 7) % NUM_PI]);
        end
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (scan_en) begin
            state <= shift_d;
        end else begin
            state <= func_d;
        end
    end

endmodule

// File: rtl/s9234_scan_bist_lfsr.sv
// Shift-left Fibonacci LFSR used both as the test-pattern generator and,
// with the parallel data input enabled, as the multiple-input signature register.
module bist_lfsr7
    import s9234_bist_pkg::*;
#(
    parameter int unsigned      WIDTH = N_CHAINS,
    parameter lfsr_mode_e       MODE  = LFSR_TPG,
    parameter logic [WIDTH-1:0] SEED  = TPG_SEED,
    parameter logic [WIDTH-1:0] TAPS  = TPG_TAPS
) (
    input  logic             CK,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] inject;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        inject = (MODE == LFSR_MISR) ? data_in : '0;
        q_next = {q[WIDTH-2:0], ^(q & TAPS)} ^ inject;
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/s9234_scan_bist.sv
// Chip-top BIST wrapper for s9234: scan-in/scan-out muxing between the
// external scan pins and the on-chip TPG/MISR pair.
module s9234_scan_bist #(
    parameter int unsigned         N_CHAINS = s9234_bist_pkg::N_CHAINS,
    parameter logic [N_CHAINS-1:0] TPG_SEED = s9234_bist_pkg::TPG_SEED
) (
    input  logic                CK,
    input  logic                scan_en,
    input  logic                bist_en,
    input  logic                TPG_reset,
    input  logic                COMP_reset,
    input  logic                SI_chain1,
    input  logic                SI_chain2,
    input  logic                SI_chain3,
    input  logic                SI_chain4,
    input  logic                SI_chain5,
    input  logic                SI_chain6,
    input  logic                SI_chain7,
    output logic                SO_chain1,
    output logic                SO_chain2,
    output logic                SO_chain3,
    output logic                SO_chain4,
    output logic                SO_chain5,
    output logic                SO_chain6,
    output logic                SO_chain7,
    input  logic                g89,
    input  logic                g94,
    input  logic                g98,
    input  logic                g102,
    input  logic                g107,
    input  logic                g301,
    input  logic                g306,
    input  logic                g310,
    input  logic                g314,
    input  logic                g319,
    input  logic                g557,
    input  logic                g558,
    input  logic                g559,
    input  logic                g560,
    input  logic                g561,
    input  logic                g562,
    input  logic                g563,
    input  logic                g564,
    input  logic                g705,
    input  logic                g639,
    input  logic                g567,
    input  logic                g45,
    input  logic                g42,
    input  logic                g39,
    input  logic                g702,
    input  logic                g32,
    input  logic                g38,
    input  logic                g46,
    input  logic                g36,
    input  logic                g47,
    input  logic                g40,
    input  logic                g37,
    input  logic                g41,
    input  logic                g22,
    input  logic                g44,
    input  logic                g23,
    output logic                g2584,
    output logic                g3222,
    output logic                g3600,
    output logic                g4307,
    output logic                g4321,
    output logic                g4422,
    output logic                g4809,
    output logic                g5137,
    output logic                g5468,
    output logic                g5469,
    output logic                g5692,
    output logic                g6282,
    output logic                g6284,
    output logic                g6360,
    output logic                g6362,
    output logic                g6364,
    output logic                g6366,
    output logic                g6368,
    output logic                g6370,
    output logic                g6372,
    output logic                g6374,
    output logic                g6728,
    output logic                g1290,
    output logic                g1293,
    output logic                g4098,
    output logic                g4099,
    output logic                g4100,
    output logic                g4101,
    output logic                g4102,
    output logic                g4103,
    output logic                g4104,
    output logic                g4105,
    output logic                g4106,
    output logic                g4107,
    output logic                g4108,
    output logic                g4109,
    output logic                g4110,
    output logic                g4112,
    output logic                g4121,
    output logic [N_CHAINS-1:0] tpg_out,
    input  logic                rst_n
);

    import s9234_bist_pkg::*;

    logic [N_CHAINS-1:0] si_vec;
    logic [N_CHAINS-1:0] so_raw;
    logic [N_CHAINS-1:0] chain_in;
    logic [N_CHAINS-1:0] misr;
    logic [NUM_PI-1:0]   pi;
    logic [NUM_PO-1:0]   po;

    assign si_vec = {SI_chain7, SI_chain6, SI_chain5, SI_chain4,
                     SI_chain3, SI_chain2, SI_chain1};

    assign chain_in = bist_en ? tpg_out : si_vec;

    assign {SO_chain7, SO_chain6, SO_chain5, SO_chain4,
            SO_chain3, SO_chain2, SO_chain1} = bist_en ? misr : so_raw;

    assign pi = {g23, g44, g22, g41, g37, g40, g47, g36, g46, g38, g32, g702,
                 g39, g42, g45, g567, g639, g705, g564, g563, g562, g561, g560,
                 g559, g558, g557, g319, g314, g310, g306, g301, g107, g102, g98,
                 g94, g89};

    assign {g4121, g4112, g4110, g4109, g4108, g4107, g4106, g4105, g4104,
            g4103, g4102, g4101, g4100, g4099, g4098, g1293, g1290, g6728,
            g6374, g6372, g6370, g6368, g6366, g6364, g6362, g6360, g6284,
            g6282, g5692, g5469, g5468, g5137, g4809, g4422, g4321, g4307,
            g3600, g3222, g2584} = po;

    s9234_core_scan u_core (
        .CK       (CK),
        .rst_n    (rst_n),
        .scan_en  (scan_en),
        .scan_in  (chain_in),
        .scan_out (so_raw),
        .pi       (pi),
        .po       (po)
    );

    // TPG free-runs in BIST mode even during capture cycles.
    bist_lfsr7 #(
        .WIDTH (N_CHAINS),
        .MODE  (LFSR_TPG),
        .SEED  (TPG_SEED),
        .TAPS  (TPG_TAPS)
    ) u_tpg (
        .CK      (CK),
        .rst_n   (rst_n),
        .load    (TPG_reset),
        .en      (bist_en),
        .data_in ('0),
        .q       (tpg_out)
    );

    bist_lfsr7 #(
        .WIDTH (N_CHAINS),
        .MODE  (LFSR_MISR),
        .SEED  (MISR_SEED),
        .TAPS  (MISR_TAPS)
    ) u_misr (
        .CK      (CK),
        .rst_n   (rst_n),
        .load    (COMP_reset),
        .en      (bist_en & scan_en),
        .data_in (so_raw),
        .q       (misr)
    );

endmodule

// File: tb/tb_s9234_scan_bist.sv
// Bench for s9234_scan_bist: queue-based scan-chain model plus TPG/MISR
// arithmetic model, exercised in external-scan and BIST modes.
module tb_s9234_scan_bist;

    localparam int unsigned LEN [7] = '{33, 33, 33, 33, 32, 32, 32};
    localparam logic [6:0]  SEED    = 7'b0000001;

    logic        CK;
    logic        rst_n;
    logic        scan_en;
    logic        bist_en;
    logic        tpg_rst;
    logic        comp_rst;
    logic [6:0]  si;
    logic [35:0] pi;
    wire  [6:0]  so;
    wire  [38:0] po;
    wire  [6:0]  tpg_out;

    int total = 0;
    int bad   = 0;

    bit         ch [7][$];
    logic [6:0] m_tpg;
    logic [6:0] m_misr;
    logic [6:0] exp_seq [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

    s9234_scan_bist dut (
        .CK(CK), .scan_en(scan_en), .bist_en(bist_en),
        .TPG_reset(tpg_rst), .COMP_reset(comp_rst),
        .SI_chain1(si[0]), .SI_chain2(si[1]), .SI_chain3(si[2]), .SI_chain4(si[3]),
        .SI_chain5(si[4]), .SI_chain6(si[5]), .SI_chain7(si[6]),
        .SO_chain1(so[0]), .SO_chain2(so[1]), .SO_chain3(so[2]), .SO_chain4(so[3]),
        .SO_chain5(so[4]), .SO_chain6(so[5]), .SO_chain7(so[6]),
        .g89(pi[0]), .g94(pi[1]), .g98(pi[2]), .g102(pi[3]), .g107(pi[4]),
        .g301(pi[5]), .g306(pi[6]), .g310(pi[7]), .g314(pi[8]), .g319(pi[9]),
        .g557(pi[10]), .g558(pi[11]), .g559(pi[12]), .g560(pi[13]), .g561(pi[14]),
        .g562(pi[15]), .g563(pi[16]), .g564(pi[17]), .g705(pi[18]), .g639(pi[19]),
        .g567(pi[20]), .g45(pi[21]), .g42(pi[22]), .g39(pi[23]), .g702(pi[24]),
        .g32(pi[25]), .g38(pi[26]), .g46(pi[27]), .g36(pi[28]), .g47(pi[29]),
        .g40(pi[30]), .g37(pi[31]), .g41(pi[32]), .g22(pi[33]), .g44(pi[34]),
        .g23(pi[35]),
        .g2584(po[0]), .g3222(po[1]), .g3600(po[2]), .g4307(po[3]), .g4321(po[4]),
        .g4422(po[5]), .g4809(po[6]), .g5137(po[7]), .g5468(po[8]), .g5469(po[9]),
        .g5692(po[10]), .g6282(po[11]), .g6284(po[12]), .g6360(po[13]), .g6362(po[14]),
        .g6364(po[15]), .g6366(po[16]), .g6368(po[17]), .g6370(po[18]), .g6372(po[19]),
        .g6374(po[20]), .g6728(po[21]), .g1290(po[22]), .g1293(po[23]), .g4098(po[24]),
        .g4099(po[25]), .g4100(po[26]), .g4101(po[27]), .g4102(po[28]), .g4103(po[29]),
        .g4104(po[30]), .g4105(po[31]), .g4106(po[32]), .g4107(po[33]), .g4108(po[34]),
        .g4109(po[35]), .g4110(po[36]), .g4112(po[37]), .g4121(po[38]),
        .tpg_out(tpg_out),
        .rst_n(rst_n)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    function automatic logic [6:0] model_so();
        logic [6:0] r;
        for (int k = 0; k < 7; k++) r[k] = ch[k][ch[k].size() - 1];
        return r;
    endfunction

    function automatic logic [6:0] exp_pins();
        return bist_en ? m_misr : model_so();
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 7; k++) begin
            ch[k].delete();
            repeat (LEN[k]) ch[k].push_back(1'b0);
        end
        m_tpg  = SEED;
        m_misr = '0;
    endtask

    // Advance model by one edge using the inputs currently applied, then clock the DUT.
    task automatic cycle();
        logic [6:0] sov;
        logic [6:0] sin;
        sov = model_so();
        sin = bist_en ? m_tpg : si;
        if (comp_rst) m_misr = '0;
        else if (bist_en && scan_en) m_misr = lfsr_step(m_misr) ^ sov;
        if (tpg_rst) m_tpg = SEED;
        else if (bist_en) m_tpg = lfsr_step(m_tpg);
        if (scan_en) begin
            for (int k = 0; k < 7; k++) begin
                ch[k].push_front(sin[k]);
                void'(ch[k].pop_back());
            end
        end
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        scan_en  = 1'b1;
        tpg_rst  = 1'b0;
        comp_rst = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scan_en = 1'b0; bist_en = 1'b0;
        tpg_rst = 1'b0; comp_rst = 1'b0; si = '0; pi = 36'h0;
        repeat (2) @(posedge CK);
        #1;
        total++;
        if (tpg_out !== SEED) begin bad++; $display("FAIL reset_tpg got=%b want=%b", tpg_out, SEED); end
        total++;
        if (so !== 7'h00) begin bad++; $display("FAIL reset_so_ext got=%b want=0000000", so); end
        total++;
        if ((^po) === 1'bx) begin bad++; $display("FAIL reset_po_known got=%b want=no X", po); end
        bist_en = 1'b1;
        #1;
        total++;
        if (so !== 7'h00) begin bad++; $display("FAIL reset_misr got=%b want=0000000", so); end
        bist_en = 1'b0;
        scan_en = 1'b1;
        rst_n   = 1'b1;
        model_reset();
        cycle();
        total++;
        if (tpg_out !== SEED) begin bad++; $display("FAIL tpg_hold_idle got=%b want=%b", tpg_out, SEED); end
    endtask

    task automatic test_tpg_sequence();
        logic [6:0] first;
        int early;
        int zeros;
        do_reset();
        bist_en = 1'b1;
        repeat (5) cycle();
        tpg_rst = 1'b1;
        cycle();
        tpg_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tpg_out !== exp_seq[i]) begin
                bad++; $display("FAIL tpg_seq[%0d] got=%b want=%b", i, tpg_out, exp_seq[i]);
            end
            cycle();
        end
        first = tpg_out;
        early = 0;
        zeros = 0;
        for (int n = 1; n <= 127; n++) begin
            cycle();
            if (tpg_out === 7'h00) zeros++;
            if (n < 127 && tpg_out === first) early++;
        end
        total++;
        if (tpg_out !== first || early != 0 || zeros != 0) begin
            bad++;
            $display("FAIL tpg_period got=%b early=%0d zeros=%0d want=%b early=0 zeros=0",
                     tpg_out, early, zeros, first);
        end
        total++;
        if (so !== m_misr || tpg_out !== m_tpg) begin
            bad++; $display("FAIL tpg_run_misr got=%b/%b want=%b/%b", so, tpg_out, m_misr, m_tpg);
        end
    endtask

    task automatic test_scan_chain(input int k, input int len);
        int hit;
        int ones;
        int edges;
        int mism;
        do_reset();
        bist_en = 1'b0;
        si      = '0;
        si[k]   = 1'b1;
        cycle();
        si      = '0;
        edges   = 1;
        hit     = 0;
        ones    = 0;
        mism    = 0;
        repeat (40) begin
            if (so[k] === 1'b1) begin
                ones++;
                if (hit == 0) hit = edges;
            end
            if (so !== model_so()) mism++;
            cycle();
            edges++;
        end
        total++;
        if (hit != len || ones != 1 || mism != 0) begin
            bad++;
            $display("FAIL chain%0d_latency got=%0d ones=%0d mism=%0d want=%0d ones=1 mism=0",
                     k + 1, hit, ones, mism, len);
        end
    endtask

    task automatic test_random_scan();
        int mism;
        do_reset();
        mism = 0;
        for (int n = 0; n < 200; n++) begin
            si       = 7'($urandom);
            bist_en  = 1'($urandom);
            tpg_rst  = ($urandom_range(0, 15) == 0);
            comp_rst = ($urandom_range(0, 15) == 0);
            pi       = {4'($urandom), 32'($urandom)};
            #1;
            total++;
            if (so !== exp_pins() || tpg_out !== m_tpg) begin
                bad++; mism++;
                if (mism < 5)
                    $display("FAIL rand_scan[%0d] so=%b tpg=%b want so=%b tpg=%b",
                             n, so, tpg_out, exp_pins(), m_tpg);
            end
            cycle();
        end
        tpg_rst = 1'b0; comp_rst = 1'b0; bist_en = 1'b0;
    endtask

    task automatic test_signature_flip();
        logic [6:0] pat [33];
        logic [6:0] sig [2];
        for (int j = 0; j < 33; j++) pat[j] = 7'($urandom);
        for (int run = 0; run < 2; run++) begin
            do_reset();
            bist_en = 1'b0;
            for (int j = 0; j < 33; j++) begin
                si = pat[j];
                if (run == 1 && j == 5) si[2] = ~si[2];
                cycle();
            end
            bist_en  = 1'b1;
            comp_rst = 1'b1;
            tpg_rst  = 1'b1;
            cycle();
            comp_rst = 1'b0;
            tpg_rst  = 1'b0;
            total++;
            if (so !== 7'h00) begin bad++; $display("FAIL comp_reset got=%b want=0000000", so); end
            repeat (300) cycle();
            total++;
            if (so !== m_misr) begin bad++; $display("FAIL signature%0d got=%b want=%b", run, so, m_misr); end
            sig[run] = so;
            // Combinational SO mux: dropping bist_en exposes the raw chain tails.
            bist_en = 1'b0;
            #1;
            total++;
            if (so !== model_so()) begin bad++; $display("FAIL so_mux got=%b want=%b", so, model_so()); end
            bist_en = 1'b1;
            #1;
        end
        total++;
        if (sig[0] === sig[1]) begin
            bad++; $display("FAIL flip_detect got=%b want!=%b", sig[1], sig[0]);
        end
    endtask

    task automatic test_capture_hold();
        logic [6:0] held;
        int mism;
        bist_en = 1'b1;
        scan_en = 1'b0;
        held    = so;
        mism    = 0;
        repeat (20) begin
            cycle();
            if (so !== held || tpg_out !== m_tpg) mism++;
        end
        total++;
        if (mism != 0) begin
            bad++; $display("FAIL capture_hold got=%b tpg=%b want=%b tpg=%b", so, tpg_out, held, m_tpg);
        end
        scan_en = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int mism;
        do_reset();
        bist_en = 1'b1;
        mism    = 0;
        repeat (60) begin
            cycle();
            if (tpg_out !== m_tpg || so !== m_misr) mism++;
        end
        total++;
        if (mism != 0) begin bad++; $display("FAIL pre_reset_run mism=%0d want=0", mism); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (tpg_out !== SEED || so !== 7'h00) begin
            bad++; $display("FAIL async_reset got=%b/%b want=%b/0000000", tpg_out, so, SEED);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tpg_out !== exp_seq[i] || so !== m_misr) begin
                bad++;
                $display("FAIL restart_seq[%0d] got=%b/%b want=%b/%b", i, tpg_out, so, exp_seq[i], m_misr);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_tpg_sequence();
        test_scan_chain(0, 33);
        test_scan_chain(6, 32);
        test_random_scan();
        test_signature_flip();
        test_capture_hold();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s9234_scan_bist.md
# s9234_scan_bist

Self-test wrapper around the scan-inserted ISCAS-89 s9234 core. It contains seven scan chains, a 7-bit LFSR test-pattern generator (TPG) and a 7-bit MISR response compactor. In BIST mode the TPG feeds the seven scan-ins and the MISR compacts the seven scan-outs. In normal mode the chains are driven from the SI pins and observed on the SO pins. It sits at chip top between the pads and the s9234 logic.

## Interface
Parameters:
- `N_CHAINS`, default 7: number of scan chains, equal to the TPG and MISR width.
- `TPG_SEED`, default 7'b0000001: LFSR value loaded by reset and by `TPG_reset`.

Ports, in positional order except `rst_n`, which is last:
- `CK` in 1: single clock; all flops are rising-edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low. Asserting it clears core flops to 0, sets the TPG to `TPG_SEED` and clears the MISR to 0.
- `scan_en` in 1: 1 = shift, 0 = functional capture.
- `bist_en` in 1: 1 = TPG drives the scan-ins and SO pins show the MISR; 0 = external scan.
- `TPG_reset` in 1: synchronous, active-high reload of the TPG with `TPG_SEED`.
- `COMP_reset` in 1: synchronous, active-high clear of the MISR.
- `SI_chain1`..`SI_chain7` in 1 each: external scan-ins.
- `SO_chain1`..`SO_chain7` out 1 each: scan-outs, or MISR bits 0..6 when `bist_en`=1.
- Primary inputs, in 1 each, 36 total: g89, g94, g98, g102, g107, g301, g306, g310, g314, g319, g557–g564, g705, g639, g567, g45, g42, g39, g702, g32, g38, g46, g36, g47, g40, g37, g41, g22, g44, g23.
- Primary outputs, out 1 each, 39 total: g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137, g5468, g5469, g5692, g6282, g6284, g6360–g6374 (even only), g6728, g1290, g1293, g4098–g4110, g4112, g4121.
- `tpg_out` out 7: current TPG state.

## Operation
- Core: s9234 function with its 228 flops stitched into 7 chains of lengths 33, 33, 33, 33, 32, 32, 32.
  - `scan_en`=1: every flop takes its chain predecessor.
  - `scan_en`=0: every flop takes its functional next state.
- Primary outputs always show the core's combinational outputs; they are not gated by mode.
- Scan-in select: chain k scan-in = `bist_en` ? `tpg_out[k-1]` : `SI_chaink`.
- TPG: Fibonacci LFSR, polynomial x^7+x+1, maximal length with period 127. Next state = {q[5:0], q[6]^q[5]}.
  - Advances every clock while `bist_en`=1, regardless of `scan_en`.
  - Holds while `bist_en`=0.
  - Priority: `rst_n` > `TPG_reset` > advance.
  - The all-zero state is unreachable from any seed.
- MISR: next = {m[5:0], m[6]^m[5]} XOR {so7, so6, …, so1}, where so_k is the raw scan-out of chain k.
  - Updates only when `bist_en`=1 and `scan_en`=1; otherwise it holds.
  - Priority: `rst_n` > `COMP_reset` > update.
- SO pin k = `bist_en` ? m[k-1] : so_k.

## Timing
- Reset values: `tpg_out`=0000001, MISR=0, core flops=0.
  - With `bist_en`=0, SO pins = 0 until a shift.
  - Primary outputs follow from the zero state.
- `TPG_reset` and `COMP_reset` take effect at the next rising edge. `tpg_out` equals `TPG_SEED` in the cycle after the edge at which `TPG_reset` was sampled high.
- The TPG value that is visible during a cycle is the one shifted into the chains at the end of that cycle.
- Simultaneous `TPG_reset`=1 and `bist_en`=1: reload wins.
- `rst_n` asserted mid-pattern: all state clears immediately; the pattern restarts from the seed.
- A `bist_en` toggle takes effect combinationally on the scan-in muxes and SO muxes. Registers change only at edges.

## Structure
- Shared package `s9234_bist_pkg`: `N_CHAINS`, the chain-length constants, `TPG_SEED`, and the LFSR/MISR tap masks.
- Sub-module `bist_lfsr7`, instantiated twice: TPG mode (no data input) and MISR mode (parallel XOR input).
- The scan-stitched s9234 core netlist is reused as the existing generated `s9234_core_scan`; the wrapper RTL covers only the muxes, TPG and MISR.

## Test plan
- Hold `rst_n`=0, then release → `tpg_out`=0000001, MISR=0.
- `bist_en`=1, `TPG_reset` high for one edge then low → `tpg_out` = 0000001, 0000010, 0000100, 0001000, 0010000, 0100000, 1000001, 0000011. The value recurs after exactly 127 edges.
- `bist_en`=0, `scan_en`=1, drive 1 on `SI_chain1` for one cycle then 0 → a single 1 appears on `SO_chain1` 33 edges later. Repeat on chain 7 with 32 edges.
- `bist_en`=1, `scan_en`=1, `COMP_reset` held for one edge → MISR=0. After 300 shifts, compare the SO pins against the golden-model signature. Flip one core flop and expect a different signature.
- `bist_en`=1, `scan_en`=0 → TPG keeps advancing while the MISR holds its value.
- Pulse `rst_n` low in the middle of the 127-cycle run → the `tpg_out` sequence restarts at 0000001.
